// File: rtl/eve_cmd_pkg.sv
// Shared field layout, payload structs and command formatting for the event-to-command dispatcher.
package eve_cmd_pkg;

    localparam int unsigned EVE_W       = 128;
    localparam int unsigned CMD_W       = 64;
    localparam int unsigned CH_W        = 3;
    localparam int unsigned TYPE_W      = 8;
    localparam int unsigned LEN_W       = 32;
    localparam int unsigned SEQ_W       = 8;
    localparam int unsigned N_DIR       = 2;
    localparam int unsigned N_CH        = 8;
    localparam int unsigned STAT_DROP_W = 16;
    localparam int unsigned STAT_PASS_W = 32;

    // Event field offsets
    localparam int unsigned EVE_DIR_BIT  = 6;
    localparam int unsigned EVE_TYPE_LSB = 8;
    localparam int unsigned EVE_LEN_LSB  = 32;

    // Command field offsets
    localparam int unsigned CMD_DIR_BIT  = 3;
    localparam int unsigned CMD_TYPE_LSB = 16;

    localparam logic DIR_CD = 1'b0;
    localparam logic DIR_CU = 1'b1;

    typedef struct packed {
        logic [EVE_W-EVE_LEN_LSB-LEN_W-1:0]         rsvd_hi;
        logic [LEN_W-1:0]                           len;
        logic [EVE_LEN_LSB-EVE_TYPE_LSB-TYPE_W-1:0] rsvd_mid;
        logic [TYPE_W-1:0]                          typ;
        logic [EVE_TYPE_LSB-EVE_DIR_BIT-2:0]        rsvd_7;
        logic                                       dir;
        logic [EVE_DIR_BIT-CH_W-1:0]                rsvd_lo;
        logic [CH_W-1:0]                            ch;
    } eve_t;

    typedef struct packed {
        logic [LEN_W-1:0]                   len;
        logic [SEQ_W-1:0]                   seq;
        logic [TYPE_W-1:0]                  typ;
        logic [CMD_TYPE_LSB-CMD_DIR_BIT-2:0] rsvd;
        logic                               dir;
        logic [CH_W-1:0]                    ch;
    } cmd_t;

    // Format an outgoing command from an event and its sequence stamp
    function automatic cmd_t build_cmd(input eve_t eve, input logic [SEQ_W-1:0] seq);
        cmd_t cmd;
        logic unused_eve_bits;
        unused_eve_bits = ^{eve.rsvd_hi, eve.rsvd_mid, eve.rsvd_7, eve.rsvd_lo};
        cmd     = '0;
        cmd.len = eve.len;
        cmd.seq = seq;
        cmd.typ = eve.typ;
        cmd.dir = eve.dir;
        cmd.ch  = eve.ch;
        return cmd;
    endfunction

endpackage

// File: rtl/eve_cmd_fifo.sv
// Synchronous command FIFO with registered ready/valid flags and extra-MSB pointer wrap.
module eve_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             user_clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_rdy,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_vld
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
    logic             push_rdy_q, pop_vld_q;
    logic             do_push, do_pop;
    logic             empty_nxt, full_nxt;

    // Next pointers and flags; a full FIFO refuses a push even when popped this cycle
    always_comb begin
        do_push    = push & push_rdy_q;
        do_pop     = pop & pop_vld_q;
        wr_ptr_nxt = wr_ptr_q + PW'(do_push);
        rd_ptr_nxt = rd_ptr_q + PW'(do_pop);
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end

    // Pointer and flag registers; ready stays low through reset
    always_ff @(posedge user_clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            push_rdy_q <= 1'b0;
            pop_vld_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_nxt;
            rd_ptr_q   <= rd_ptr_nxt;
            push_rdy_q <= ~full_nxt;
            pop_vld_q  <= ~empty_nxt;
        end
    end

    // Storage write
    always_ff @(posedge user_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign push_rdy = push_rdy_q;
    assign pop_vld  = pop_vld_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/eve_cmd_dispatch.sv
// Per-chain event-to-command dispatcher: enable filter, per-(dir,ch) sequence stamp, command FIFO.
// Optional statistics counters built when EVE_CMD_DISPATCH_STAT_EN is defined.
module eve_cmd_dispatch
    import eve_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CH_PER_DIR = 8
) (
    input  logic                   user_clk,
    input  logic                   reset,
    input  logic                   s_axis_transfer_eve_tvalid,
    input  logic [EVE_W-1:0]       s_axis_transfer_eve_tdata,
    output logic                   s_axis_transfer_eve_tready,
    output logic                   m_axis_transfer_cmd_tvalid,
    output logic [CMD_W-1:0]       m_axis_transfer_cmd_tdata,
    input  logic                   m_axis_transfer_cmd_tready,
    input  logic [N_CH-1:0]        dma_rx_ch_connection_enable,
    input  logic [N_CH-1:0]        dma_tx_ch_connection_enable,
    output logic [STAT_DROP_W-1:0] stat_drop_cnt,
    output logic [STAT_PASS_W-1:0] stat_pass_cnt
);

    eve_t             eve;
    cmd_t             cmd;
    logic [N_CH-1:0]  en_dir [N_DIR];
    logic [SEQ_W-1:0] seq_q  [N_DIR][N_CH];
    logic             ch_ok, sel, accept, push;
    logic             unused_rsvd;

    // Decode event, select the direction's enable and format the command
    always_comb begin
        eve            = eve_t'(s_axis_transfer_eve_tdata);
        en_dir[DIR_CD] = dma_rx_ch_connection_enable;
        en_dir[DIR_CU] = dma_tx_ch_connection_enable;
        ch_ok          = (32'(eve.ch) < CH_PER_DIR);
        sel            = ch_ok & en_dir[eve.dir][eve.ch];
        accept         = s_axis_transfer_eve_tvalid & s_axis_transfer_eve_tready;
        push           = accept & sel;
        cmd            = build_cmd(eve, seq_q[eve.dir][eve.ch]);
        unused_rsvd    = ^{eve.rsvd_hi, eve.rsvd_mid, eve.rsvd_7, eve.rsvd_lo};
    end

    // Sequence counters: cleared while disabled, bumped on each forwarded event
    always_ff @(posedge user_clk) begin
        for (int d = 0; d < N_DIR; d++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (reset || !en_dir[d][c]) begin
                    seq_q[d][c] <= '0;
                end else if (push && (eve.dir == 1'(d)) && (eve.ch == CH_W'(c))) begin
                    seq_q[d][c] <= seq_q[d][c] + SEQ_W'(1);
                end
            end
        end
    end

    eve_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .user_clk  (user_clk),
        .reset     (reset),
        .push      (push),
        .push_data (cmd),
        .push_rdy  (s_axis_transfer_eve_tready),
        .pop       (m_axis_transfer_cmd_tready),
        .pop_data  (m_axis_transfer_cmd_tdata),
        .pop_vld   (m_axis_transfer_cmd_tvalid)
    );

`ifdef EVE_CMD_DISPATCH_STAT_EN
    logic                   drop;
    logic [STAT_DROP_W-1:0] drop_cnt_q;
    logic [STAT_PASS_W-1:0] pass_cnt_q;

    assign drop = accept & ~sel;

    // Saturating drop/pass statistics
    always_ff @(posedge user_clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
            pass_cnt_q <= '0;
        end else begin
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + STAT_DROP_W'(1);
            end
            if (push && (pass_cnt_q != '1)) begin
                pass_cnt_q <= pass_cnt_q + STAT_PASS_W'(1);
            end
        end
    end

    assign stat_drop_cnt = drop_cnt_q;
    assign stat_pass_cnt = pass_cnt_q;
`else
    assign stat_drop_cnt = '0;
    assign stat_pass_cnt = '0;
`endif

endmodule

// File: tb/tb_eve_cmd_dispatch.sv
// Scoreboard bench for eve_cmd_dispatch; honours EVE_CMD_DISPATCH_STAT_EN for stat expectations.
`timescale 1ns/1ps
module tb_eve_cmd_dispatch;

`ifdef EVE_CMD_DISPATCH_STAT_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic         user_clk = 1'b0;
    logic         reset;
    logic         ev_valid;
    logic [127:0] ev_data;
    logic         ev_ready;
    logic         cmd_valid;
    logic [63:0]  cmd_data;
    logic         cmd_ready;
    logic [7:0]   rx_en, tx_en;
    logic [15:0]  stat_drop;
    logic [31:0]  stat_pass;

    always #5 user_clk = ~user_clk;

    eve_cmd_dispatch #(.FIFO_DEPTH(4), .CH_PER_DIR(8)) dut (
        .user_clk                    (user_clk),
        .reset                       (reset),
        .s_axis_transfer_eve_tvalid  (ev_valid),
        .s_axis_transfer_eve_tdata   (ev_data),
        .s_axis_transfer_eve_tready  (ev_ready),
        .m_axis_transfer_cmd_tvalid  (cmd_valid),
        .m_axis_transfer_cmd_tdata   (cmd_data),
        .m_axis_transfer_cmd_tready  (cmd_ready),
        .dma_rx_ch_connection_enable (rx_en),
        .dma_tx_ch_connection_enable (tx_en),
        .stat_drop_cnt               (stat_drop),
        .stat_pass_cnt               (stat_pass)
    );

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;
    logic [63:0] sb [$];
    logic [7:0]  m_seq [2][8];
    int unsigned exp_drop = 0;
    int unsigned exp_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic set_en(input logic [7:0] rx, input logic [7:0] tx);
        rx_en = rx;
        tx_en = tx;
        for (int c = 0; c < 8; c++) begin
            if (!rx[c]) m_seq[0][c] = 8'h00;
            if (!tx[c]) m_seq[1][c] = 8'h00;
        end
    endtask

    // Present one event; model the result at the accepting edge; returns cycles waited
    task automatic send(input logic [2:0] ch, input logic dir, input logic [7:0] typ,
                        input logic [31:0] len, output int waited);
        logic acc;
        logic en;
        acc      = 1'b0;
        waited   = 0;
        ev_valid = 1'b1;
        ev_data  = {$urandom(), $urandom(), len, 16'($urandom()), typ,
                    1'($urandom()), dir, 3'($urandom()), ch};
        for (int i = 0; i < 40; i++) begin
            @(negedge user_clk);
            if (ev_ready) begin
                acc = 1'b1;
                break;
            end
            waited++;
        end
        if (acc) begin
            en = dir ? tx_en[ch] : rx_en[ch];
            if (en) begin
                sb.push_back({len, m_seq[dir][ch], typ, 12'h000, dir, ch});
                m_seq[dir][ch] = m_seq[dir][ch] + 8'd1;
                exp_pass++;
            end else begin
                exp_drop++;
            end
        end else begin
            chk("send_timeout", 64'(waited), 64'd0);
        end
        @(posedge user_clk);
        #1;
        ev_valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty, then require the DUT to have nothing left
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge user_clk);
            n++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        @(negedge user_clk);
        chk("drain_valid", 64'(cmd_valid), 64'd0);
        step();
    endtask

    // Output monitor: hold rule on stalls, in-order compare on every handshake
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;
    always @(negedge user_clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(cmd_valid), 64'd1);
                chk("hold_data", cmd_data, prev_data);
            end
            if (cmd_valid && cmd_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("cmd_data", cmd_data, sb.pop_front());
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_data  = cmd_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1, "watchdog expired");
    end

    int w, w5;

    initial begin
        reset     = 1'b1;
        ev_valid  = 1'b0;
        ev_data   = '0;
        cmd_ready = 1'b0;
        set_en(8'h00, 8'h00);

        // Reset state
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        chk("rst_m_tvalid", 64'(cmd_valid), 64'd0);
        chk("rst_s_tready", 64'(ev_ready), 64'd0);
        chk("rst_drop_cnt", 64'(stat_drop), 64'd0);
        chk("rst_pass_cnt", 64'(stat_pass), 64'd0);
        step();
        reset = 1'b0;
        step();
        step();
        @(negedge user_clk);
        chk("ready_after_rst", 64'(ev_ready), 64'd1);
        step();

        // T1: single event, one-cycle latency, exact command format
        set_en(8'h01, 8'h00);
        cmd_ready = 1'b1;
        send(3'd0, 1'b0, 8'h05, 32'h0000_0100, w);
        chk("t1_wait", 64'(w), 64'd0);
        @(negedge user_clk);
        chk("t1_valid", 64'(cmd_valid), 64'd1);
        chk("t1_data", cmd_data, 64'h0000_0100_0005_0000);
        step();
        drain();

        // T2: clear counter via disable, then 257 back-to-back events wrap the sequence
        set_en(8'h00, 8'h00);
        step();
        set_en(8'h01, 8'h00);
        for (int i = 0; i < 257; i++) begin
            send(3'd0, 1'b0, 8'(i), 32'h1000 + 32'(i), w);
        end
        drain();

        // T3: disabled CU channel event is consumed and dropped
        send(3'd2, 1'b1, 8'h33, 32'h55, w);
        chk("t3_accept_wait", 64'(w), 64'd0);
        @(negedge user_clk);
        chk("t3_no_cmd", 64'(cmd_valid), 64'd0);
        chk("t3_drop_cnt", 64'(stat_drop), STAT_ON ? 64'(exp_drop) : 64'd0);
        chk("t3_pass_cnt", 64'(stat_pass), STAT_ON ? 64'(exp_pass) : 64'd0);
        step();

        // T4: fill with output stalled, fifth event waits for one pop
        set_en(8'hFF, 8'hFF);
        cmd_ready = 1'b0;
        send(3'd1, 1'b0, 8'h41, 32'h4001, w);
        chk("t4_w1", 64'(w), 64'd0);
        send(3'd3, 1'b1, 8'h42, 32'h4002, w);
        chk("t4_w2", 64'(w), 64'd0);
        send(3'd7, 1'b0, 8'h43, 32'h4003, w);
        chk("t4_w3", 64'(w), 64'd0);
        send(3'd3, 1'b1, 8'h44, 32'h4004, w);
        chk("t4_w4", 64'(w), 64'd0);
        fork
            send(3'd5, 1'b1, 8'h45, 32'h4005, w5);
            begin
                @(negedge user_clk);
                chk("t4_full_ready", 64'(ev_ready), 64'd0);
                @(negedge user_clk);
                chk("t4_still_full", 64'(ev_ready), 64'd0);
                step();
                cmd_ready = 1'b1;
                @(negedge user_clk);
                chk("t4_no_bypass", 64'(ev_ready), 64'd0);
                step();
                cmd_ready = 1'b0;
                @(negedge user_clk);
                chk("t4_ready_after_pop", 64'(ev_ready), 64'd1);
            end
        join
        chk("t4_5th_wait", 64'(w5), 64'd3);
        cmd_ready = 1'b1;
        drain();

        // T5: occupancy 2 held across 10 cycles of simultaneous push and pop
        cmd_ready = 1'b0;
        send(3'd4, 1'b0, 8'h50, 32'h5000, w);
        send(3'd6, 1'b1, 8'h51, 32'h5001, w);
        cmd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(3'(i), 1'(i), 8'h60 + 8'(i), 32'h6000 + 32'(i), w);
            chk("t5_stream_wait", 64'(w), 64'd0);
        end
        cmd_ready = 1'b0;
        send(3'd2, 1'b0, 8'h70, 32'h7000, w);
        chk("t5_fill1_wait", 64'(w), 64'd0);
        send(3'd2, 1'b1, 8'h71, 32'h7001, w);
        chk("t5_fill2_wait", 64'(w), 64'd0);
        @(negedge user_clk);
        chk("t5_occ_full", 64'(ev_ready), 64'd0);
        step();
        cmd_ready = 1'b1;
        drain();

        // T6: reset with commands queued flushes them and restarts sequence numbers
        cmd_ready = 1'b0;
        send(3'd0, 1'b0, 8'h80, 32'h8000, w);
        send(3'd1, 1'b1, 8'h81, 32'h8001, w);
        send(3'd0, 1'b0, 8'h82, 32'h8002, w);
        reset = 1'b1;
        sb.delete();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 8; c++) m_seq[d][c] = 8'h00;
        end
        exp_drop = 0;
        exp_pass = 0;
        step();
        reset = 1'b0;
        @(negedge user_clk);
        chk("t6_valid_after_rst", 64'(cmd_valid), 64'd0);
        chk("t6_ready_in_rst", 64'(ev_ready), 64'd0);
        chk("t6_drop_cleared", 64'(stat_drop), 64'd0);
        chk("t6_pass_cleared", 64'(stat_pass), 64'd0);
        step();
        cmd_ready = 1'b1;
        send(3'd0, 1'b0, 8'h77, 32'h7777, w);
        @(negedge user_clk);
        chk("t6_seq_restart", 64'(cmd_data[31:24]), 64'd0);
        step();
        drain();
        @(negedge user_clk);
        chk("end_pass_cnt", 64'(stat_pass), STAT_ON ? 64'(exp_pass) : 64'd0);
        chk("end_drop_cnt", 64'(stat_drop), STAT_ON ? 64'(exp_drop) : 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
